// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for eight requesters sharing one 8:1 data mux; ARB_BURST_LIMIT_EN caps grant length at MAX_BURST.
// Latency: grant one cycle after a request is sampled; dout is combinational from registered sel/busy.
// Backpressure: none; a grant is held while its requester keeps req high and releases through one IDLE cycle.
module mux8_rr_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] din,
    output logic [2:0] sel,
    output logic [7:0] gnt,
    output logic       busy,
    output logic       dout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic       found;
    logic [2:0] winner;
    logic       burst_end;

    if (MAX_BURST < 2 || MAX_BURST > 16) begin : g_bad_max_burst
        $error("mux8_rr_arbiter: MAX_BURST must be in 2..16");
    end

    // Scan from the highest offset down so the lowest offset from ptr wins last.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        for (int i = 7; i >= 0; i--) begin
            if (req[3'(ptr + 3'(i))]) begin
                found  = 1'b1;
                winner = 3'(ptr + 3'(i));
            end
        end
    end

`ifdef ARB_BURST_LIMIT_EN
    logic [3:0] burst_cnt;

    // burst_cnt counts completed GRANT cycles minus one, so the grant lasts exactly MAX_BURST cycles.
    assign burst_end = (burst_cnt == 4'(MAX_BURST - 1));
`else
    assign burst_end = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sel   <= 3'd0;
            gnt   <= 8'h00;
            busy  <= 1'b0;
            ptr   <= 3'd0;
`ifdef ARB_BURST_LIMIT_EN
            burst_cnt <= 4'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANT;
                        sel   <= winner;
                        gnt   <= 8'(1) << winner;
                        busy  <= 1'b1;
                        ptr   <= 3'(winner + 3'd1);
`ifdef ARB_BURST_LIMIT_EN
                        burst_cnt <= 4'd0;
`endif
                    end
                end
                GRANT: begin
                    if (!req[sel] || burst_end) begin
                        state <= IDLE;
                        gnt   <= 8'h00;
                        busy  <= 1'b0;
                    end
`ifdef ARB_BURST_LIMIT_EN
                    else begin
                        burst_cnt <= burst_cnt + 4'd1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                    gnt   <= 8'h00;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign dout = busy & din[sel];

endmodule
